inst_fetch_buffer: RTL and testbench

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/inst_fetch_buffer_if.sv | 28 ++
 rtl/inst_fetch_buffer.sv | 104 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_if.sv
// Bundles the instruction-memory request/response, redirect and decode-side
// handshake of the fetch buffer; master is the buffer, slave its environment.
interface inst_fetch_buffer_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_PC;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_PC;
  logic [INSTR_WIDTH-1:0] out_Instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_PC, out_Instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_PC, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_PC, out_Instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_PC, out_ready
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues one fetch at a time, queues {PC, Instr}
// pairs for decode, and flushes/refetches on a branch redirect.
module inst_fetch_buffer #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
  input logic                 clk,
  input logic                 rst,
  inst_fetch_buffer_if.master fb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PC_WIDTH-1:0]    fetch_PC;
  logic [PC_WIDTH-1:0]    req_PC;
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   req_valid;
  logic                   req_fire;
  logic                   push;
  logic                   pop;
  logic                   unused_redirect_low;

  // A request is only offered with no fetch in flight and a free slot for its data.
  assign req_valid = rst && (state == ST_IDLE) && (count < CNT_W'(DEPTH)) && !fb.redirect;
  assign req_fire  = req_valid && fb.imem_req_ready;
  assign pop       = (count != '0) && fb.out_ready && !fb.redirect;

  assign fb.imem_req_valid = req_valid;
  assign fb.imem_req_addr  = fetch_PC;
  assign fb.out_valid      = (count != '0);
  assign fb.out_PC         = pc_mem[rd_ptr];
  assign fb.out_Instr      = instr_mem[rd_ptr];

  assign unused_redirect_low = ^fb.redirect_PC[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_fire) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A redirect kills the in-flight fetch; if its data is already here it is simply dropped.
        if (fb.redirect) begin
          state_nxt = fb.imem_rsp_valid ? ST_IDLE : ST_DROP;
        end else if (fb.imem_rsp_valid) begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (fb.imem_rsp_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_PC <= RESET_PC;
      req_PC   <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (fb.redirect) begin
      fetch_PC <= {fb.redirect_PC[PC_WIDTH-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (req_fire) begin
        req_PC   <= fetch_PC;
        fetch_PC <= fetch_PC + PC_WIDTH'(4);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_PC;
      instr_mem[wr_ptr] <= fb.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench: a queue-level reference model of the fetch buffer plus a
// simple instruction memory returning ~addr after a programmable latency.
module tb_inst_fetch_buffer;
  localparam int          PC_WIDTH    = 32;
  localparam int          INSTR_WIDTH = 32;
  localparam int          DEPTH       = 4;
  localparam logic [31:0] RESET_PC    = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_buffer_if #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) bus ();

  inst_fetch_buffer #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fb (bus)
  );

  entry_t      exp_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_discard;
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          rsp_lat;
  logic [31:0] seen_pcs[$];
  logic [31:0] req_addrs[$];
  bit          ov_log[$];
  bit          rv_log[$];
  int          errors = 0;
  int          checks = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit modelReqValid();
    return !m_busy && !m_discard && (exp_q.size() < DEPTH) && !bus.redirect;
  endfunction

  task automatic checkOutput();
    bit exp_rv;
    exp_rv = modelReqValid();
    checkVal("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) checkVal("req_addr", bus.imem_req_addr, m_fetch_pc);
    checkVal("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkVal("out_PC", bus.out_PC, exp_q[0].pc);
      checkVal("out_Instr", bus.out_Instr, exp_q[0].instr);
    end
    ov_log.push_back(bus.out_valid);
    rv_log.push_back(bus.imem_req_valid);
    if (bus.imem_req_valid && bus.imem_req_ready) req_addrs.push_back(bus.imem_req_addr);
    if (bus.out_valid && bus.out_ready && !bus.redirect) seen_pcs.push_back(bus.out_PC);
  endtask

  // Advance the reference model and the memory across one rising edge.
  task automatic updateModel();
    bit     exp_rv;
    bit     do_pop;
    entry_t e;
    exp_rv = modelReqValid();
    do_pop = (exp_q.size() != 0) && bus.out_ready;
    if (bus.redirect) begin
      exp_q.delete();
      m_fetch_pc = {bus.redirect_PC[31:2], 2'b00};
      if (m_busy) begin
        m_busy    = 1'b0;
        m_discard = !bus.imem_rsp_valid;
      end else if (m_discard && bus.imem_rsp_valid) begin
        m_discard = 1'b0;
      end
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (m_discard && bus.imem_rsp_valid) begin
        m_discard = 1'b0;
      end else if (m_busy && bus.imem_rsp_valid) begin
        e.pc    = m_req_pc;
        e.instr = bus.imem_rsp_data;
        exp_q.push_back(e);
        m_busy  = 1'b0;
      end
      if (exp_rv && bus.imem_req_ready) begin
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_busy     = 1'b1;
      end
    end
    if (mem_pending) begin
      if (mem_cnt <= 1) mem_pending = 1'b0;
      else mem_cnt--;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mem_pending = 1'b1;
      mem_addr    = bus.imem_req_addr;
      mem_cnt     = rsp_lat;
    end
  endtask

  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit oready, input bit ready);
    bus.redirect       = redir;
    bus.redirect_PC    = rpc;
    bus.out_ready      = oready;
    bus.imem_req_ready = ready;
    bus.imem_rsp_valid = mem_pending && (mem_cnt == 1);
    bus.imem_rsp_data  = mem_pending ? ~mem_addr : 32'h0;
    @(negedge clk);
    checkOutput();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    seen_pcs.delete();
    req_addrs.delete();
    ov_log.delete();
    rv_log.delete();
  endtask

  task automatic doReset();
    rst                = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_PC    = 32'h0;
    bus.out_ready      = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    #1;
    checkVal("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    checkVal("rst_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    m_fetch_pc  = RESET_PC;
    m_req_pc    = RESET_PC;
    m_busy      = 1'b0;
    m_discard   = 1'b0;
    mem_pending = 1'b0;
    mem_cnt     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clearLogs();
  endtask

  initial begin
    int ones;
    rsp_lat = 1;

    // Streaming fetch with single-cycle memory and decode always ready.
    doReset();
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("a_pc0", (seen_pcs.size() > 0) ? seen_pcs[0] : 32'hx, 32'h8000_0000);
    checkVal("a_pc1", (seen_pcs.size() > 1) ? seen_pcs[1] : 32'hx, 32'h8000_0004);
    checkVal("a_pc2", (seen_pcs.size() > 2) ? seen_pcs[2] : 32'hx, 32'h8000_0008);

    // Decode stalled: queue fills to DEPTH and fetching stops, then drains in order.
    doReset();
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkVal("b_model_full", 32'(exp_q.size()), 32'd4);
    checkVal("b_req_stopped", 32'(rv_log[rv_log.size()-1]), 32'd0);
    checkVal("b_head_pc", bus.out_PC, 32'h8000_0000);
    clearLogs();
    repeat (14) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("b_pc0", (seen_pcs.size() > 0) ? seen_pcs[0] : 32'hx, 32'h8000_0000);
    checkVal("b_pc1", (seen_pcs.size() > 1) ? seen_pcs[1] : 32'hx, 32'h8000_0004);
    checkVal("b_pc2", (seen_pcs.size() > 2) ? seen_pcs[2] : 32'hx, 32'h8000_0008);
    checkVal("b_pc3", (seen_pcs.size() > 3) ? seen_pcs[3] : 32'hx, 32'h8000_000C);
    checkVal("b_pc4", (seen_pcs.size() > 4) ? seen_pcs[4] : 32'hx, 32'h8000_0010);

    // Redirect while waiting; the late response must be dropped.
    rsp_lat = 3;
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    clearLogs();
    applyStimulus(1'b1, 32'h8000_0103, 1'b1, 1'b1);
    repeat (9) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("c_next_addr", (req_addrs.size() > 0) ? req_addrs[0] : 32'hx, 32'h8000_0100);
    ones = 0;
    for (int i = 0; i < 7 && i < ov_log.size(); i++) ones += int'(ov_log[i]);
    checkVal("c_no_early_out", 32'(ones), 32'd0);
    checkVal("c_first_pc", (seen_pcs.size() > 0) ? seen_pcs[0] : 32'hx, 32'h8000_0100);

    // Redirect coinciding with a response while two entries are queued.
    rsp_lat = 1;
    doReset();
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkVal("d_model_count", 32'(exp_q.size()), 32'd2);
    clearLogs();
    applyStimulus(1'b1, 32'h9000_0010, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("d_flushed", (ov_log.size() > 1) ? 32'(ov_log[1]) : 32'hx, 32'd0);
    checkVal("d_req_next", (rv_log.size() > 1) ? 32'(rv_log[1]) : 32'hx, 32'd1);
    checkVal("d_next_addr", (req_addrs.size() > 0) ? req_addrs[0] : 32'hx, 32'h9000_0010);
    checkVal("d_first_pc", (seen_pcs.size() > 0) ? seen_pcs[0] : 32'hx, 32'h9000_0010);

    // Simultaneous push and pop with two entries queued.
    doReset();
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    clearLogs();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("e_model_count", 32'(exp_q.size()), 32'd2);
    checkVal("e_head_after", bus.out_PC, 32'h8000_0004);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("e_pc0", (seen_pcs.size() > 0) ? seen_pcs[0] : 32'hx, 32'h8000_0000);
    checkVal("e_pc1", (seen_pcs.size() > 1) ? seen_pcs[1] : 32'hx, 32'h8000_0004);
    checkVal("e_pc2", (seen_pcs.size() > 2) ? seen_pcs[2] : 32'hx, 32'h8000_0008);
    checkVal("e_pc3", (seen_pcs.size() > 3) ? seen_pcs[3] : 32'hx, 32'h8000_000C);

    // Asynchronous reset mid-fetch with three entries queued.
    doReset();
    repeat (7) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkVal("f_model_count", 32'(exp_q.size()), 32'd3);
    checkVal("f_pre_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    checkVal("f_async_req_valid", 32'(bus.imem_req_valid), 32'd0);
    checkVal("f_async_out_valid", 32'(bus.out_valid), 32'd0);
    doReset();
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkVal("f_next_addr", (req_addrs.size() > 0) ? req_addrs[0] : 32'hx, 32'h8000_0000);
    checkVal("f_first_pc", (seen_pcs.size() > 0) ? seen_pcs[0] : 32'hx, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
